// File: rtl/mic_pkg.sv
// Shared types and helpers for the multi-channel microphone level meter.
//   sample_t     : signed microphone sample at the default sample width
//   level_t      : unsigned rectified/decayed level at the default level width
//   scan_state_t : states of the loudest-channel scan
//   abs_sat()    : magnitude of a sample; the most-negative code saturates
//                  to the largest positive code instead of wrapping
package mic_pkg;

  localparam int SAMPLE_W = 24;
  localparam int LEVEL_W  = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [LEVEL_W-1:0]  level_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  function automatic sample_t abs_sat(input sample_t s);
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) return {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (s[SAMPLE_W-1])                return -s;
    else                                   return s;
  endfunction

endpackage

// File: rtl/mic_level_chan.sv
// One microphone channel: rectify with saturation, peak-hold with optional
// hold time, exponential decay, and registered PWM LED compare.
//   clk, rst_n   : clock, synchronous active-low reset
//   sample_valid : stage-1 enable, captures |sample|
//   update       : stage-2 enable (strobe delayed one cycle), updates level
//   sample       : signed input sample
//   pwm_cnt      : shared free-running PWM counter
//   level        : current level
//   led          : PWM LED output
module mic_level_chan #(
  parameter int SAMPLE_W     = mic_pkg::SAMPLE_W,
  parameter int LEVEL_W      = mic_pkg::LEVEL_W,
  parameter int PWM_W        = 8,
  parameter int DECAY_SHIFT  = 4,
  parameter int HOLD_SAMPLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic                update,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [PWM_W-1:0]    pwm_cnt,
  output logic [LEVEL_W-1:0]  level,
  output logic                led
);

  localparam int HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);
  localparam logic [SAMPLE_W-1:0] MOST_NEG  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MAX_POS   = {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [SAMPLE_W-1:0] abs_d;
  logic [LEVEL_W-1:0]  peak_q;
  logic [LEVEL_W-1:0]  step;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                unused_abs_lsbs;

  always_comb begin
    if (sample == MOST_NEG)       abs_d = MAX_POS;
    else if (sample[SAMPLE_W-1])  abs_d = -sample;
    else                          abs_d = sample;
  end

  // Only the top LEVEL_W bits of the magnitude ever reach the level.
  assign unused_abs_lsbs = ^abs_d[SAMPLE_W-LEVEL_W-1:0];

  // Small levels would stall at a shift result of zero; force a unit step
  // so every level eventually decays to 0.
  always_comb begin
    step = level >> DECAY_SHIFT;
    if (step == '0 && level != '0) step = LEVEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q   <= '0;
      level    <= '0;
      hold_cnt <= '0;
      led      <= 1'b0;
    end else begin
      if (sample_valid) peak_q <= abs_d[SAMPLE_W-1 -: LEVEL_W];
      if (update) begin
        if (peak_q >= level) begin
          level    <= peak_q;
          hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end else begin
          level <= level - step;
        end
      end
      led <= (pwm_cnt < level[LEVEL_W-1 -: PWM_W]);
    end
  end

endmodule

// File: rtl/mic_level_array.sv
// Multi-channel microphone level meter with loudest-channel scan.
//   clk, rst_n    : clock, synchronous active-low reset
//   sample_valid  : one-cycle strobe, all channel samples valid together
//   samples       : signed samples, ch k at [k*SAMPLE_W +: SAMPLE_W]
//   led           : per-channel PWM LED
//   levels        : per-channel level, ch k at [k*LEVEL_W +: LEVEL_W]
//   loudest_ch    : loudest channel of the last completed scan
//   loudest_level : its level at scan snapshot
//   loudest_valid : one-cycle pulse when loudest_ch/loudest_level update
//
// state | meaning
// IDLE  | waiting; level update or pending request snapshots levels
// SCAN  | compares one snapshot channel per cycle against running best
// DONE  | result registered, pulse high; returns to IDLE
module mic_level_array
  import mic_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SAMPLE_W     = mic_pkg::SAMPLE_W,
  parameter int LEVEL_W      = mic_pkg::LEVEL_W,
  parameter int PWM_W        = 8,
  parameter int DECAY_SHIFT  = 4,
  parameter int HOLD_SAMPLES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] samples,
  output logic [NUM_CH-1:0]          led,
  output logic [NUM_CH*LEVEL_W-1:0]  levels,
  output logic [$clog2(NUM_CH)-1:0]  loudest_ch,
  output logic [LEVEL_W-1:0]         loudest_level,
  output logic                       loudest_valid
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [PWM_W-1:0]   pwm_cnt;
  logic               v1, v2;
  logic [LEVEL_W-1:0] lvl  [NUM_CH];
  logic [LEVEL_W-1:0] snap [NUM_CH];
  logic [LEVEL_W-1:0] best_lvl;
  logic [CH_W-1:0]    best_ch;
  logic [CH_W-1:0]    idx;
  logic               pending;
  scan_state_t        state, state_d;
  logic               start, take, last;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    mic_level_chan #(
      .SAMPLE_W    (SAMPLE_W),
      .LEVEL_W     (LEVEL_W),
      .PWM_W       (PWM_W),
      .DECAY_SHIFT (DECAY_SHIFT),
      .HOLD_SAMPLES(HOLD_SAMPLES)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_valid(sample_valid),
      .update      (v1),
      .sample      (samples[k*SAMPLE_W +: SAMPLE_W]),
      .pwm_cnt     (pwm_cnt),
      .level       (lvl[k]),
      .led         (led[k])
    );
    assign levels[k*LEVEL_W +: LEVEL_W] = lvl[k];
  end

  // v2 marks the cycle in which a strobe's new levels become visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      v1      <= sample_valid;
      v2      <= v1;
    end
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    take    = (snap[idx] > best_lvl);
    last    = (idx == LAST_CH);
    case (state)
      IDLE: if (v2 || pending) begin
        start   = 1'b1;
        state_d = SCAN;
      end
      SCAN:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
      best_lvl      <= '0;
      best_ch       <= '0;
      idx           <= '0;
      pending       <= 1'b0;
      loudest_ch    <= '0;
      loudest_level <= '0;
      loudest_valid <= 1'b0;
    end else begin
      loudest_valid <= 1'b0;
      // A start consumes both the pending request and a same-cycle update.
      if (start)   pending <= 1'b0;
      else if (v2) pending <= 1'b1;
      if (start) begin
        snap     <= lvl;
        best_lvl <= lvl[0];
        best_ch  <= '0;
        idx      <= CH_W'(1);
      end
      if (state == SCAN) begin
        if (take) begin
          best_lvl <= snap[idx];
          best_ch  <= idx;
        end
        idx <= idx + CH_W'(1);
        // Result is registered on entry to DONE so the pulse and data align.
        if (last) begin
          loudest_ch    <= take ? idx : best_ch;
          loudest_level <= take ? snap[idx] : best_lvl;
          loudest_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mic_level_array.sv
module tb_mic_level_array;
  localparam int NCH = 4;
  localparam int SW  = 24;
  localparam int LW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                sample_valid = 1'b0;
  logic [NCH*SW-1:0]   samples = '0;
  logic [NCH-1:0]      led;
  logic [NCH*LW-1:0]   levels;
  logic [1:0]          loudest_ch;
  logic [LW-1:0]       loudest_level;
  logic                loudest_valid;

  logic                b_valid = 1'b0;
  logic [NCH*SW-1:0]   b_samples = '0;
  logic [NCH-1:0]      b_led;
  logic [NCH*LW-1:0]   b_levels;
  logic [1:0]          b_loudest_ch;
  logic [LW-1:0]       b_loudest_level;
  logic                b_loudest_valid;

  mic_level_array #(.NUM_CH(NCH), .SAMPLE_W(SW), .LEVEL_W(LW), .PWM_W(8),
                    .DECAY_SHIFT(4), .HOLD_SAMPLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .samples(samples),
    .led(led), .levels(levels), .loudest_ch(loudest_ch),
    .loudest_level(loudest_level), .loudest_valid(loudest_valid));

  mic_level_array #(.NUM_CH(NCH), .SAMPLE_W(SW), .LEVEL_W(LW), .PWM_W(8),
                    .DECAY_SHIFT(4), .HOLD_SAMPLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_valid(b_valid), .samples(b_samples),
    .led(b_led), .levels(b_levels), .loudest_ch(b_loudest_ch),
    .loudest_level(b_loudest_level), .loudest_valid(b_loudest_valid));

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int          mlev [NCH];
  logic [63:0] vis  [64];
  bit          upd  [64];
  int          cyc = 0;
  int          last_start;
  bit          pend;
  int          exp_ch, exp_lvl;
  int          pulse_cnt = 0, exp_pulse_cnt = 0, pulse_cyc = 0;
  int          pulse_ch = 0, pulse_lvl = 0;
  int          led_hi [NCH];
  bit          gap_en = 0;
  int          prev_pulse = -1, bad_gap = 0;

  typedef struct {
    logic [95:0] s;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int peak_of(input logic [23:0] s);
    int v;
    v = int'(signed'(s));
    if (v < 0) v = -v;
    if (v > 32'h7FFFFF) v = 32'h7FFFFF;
    return v >>> 8;
  endfunction

  function automatic logic [63:0] pack_model();
    logic [63:0] r;
    for (int k = 0; k < NCH; k++) r[k*16 +: 16] = 16'(mlev[k]);
    return r;
  endfunction

  // loudest channel by plain comparison, lowest index wins ties
  function automatic int argmax_ch(input logic [63:0] lv);
    int b;
    b = 0;
    for (int k = 1; k < NCH; k++) if (lv[k*16 +: 16] > lv[b*16 +: 16]) b = k;
    return b;
  endfunction

  function automatic logic [23:0] rnd_sample();
    case ($urandom_range(0, 5))
      0:       return 24'h0;
      1:       return 24'h800000;
      2:       return 24'h7FFFFF;
      3:       return 24'($urandom_range(0, 4095));
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) mlev[k] = 0;
    for (int i = 0; i < 64; i++) begin vis[i] = '0; upd[i] = 0; end
    pend = 0;
    last_start = -1000;
  endtask

  task automatic model_strobe(input logic [95:0] s);
    int p, d;
    for (int k = 0; k < NCH; k++) begin
      p = peak_of(s[k*24 +: 24]);
      if (p >= mlev[k]) mlev[k] = p;
      else begin
        d = mlev[k] >> 4;
        if (d == 0 && mlev[k] != 0) d = 1;
        mlev[k] = mlev[k] - d;
      end
    end
  endtask

  task automatic tick(input logic v, input logic [95:0] s);
    bit u, expv;
    sample_valid = v;
    samples = s;
    if (v) model_strobe(s);
    vis[(cyc + 2) % 64] = pack_model();
    upd[(cyc + 2) % 64] = v;
    @(posedge clk); #1;
    cyc++;
    chk("levels", levels, vis[cyc % 64]);
    for (int k = 0; k < NCH; k++) led_hi[k] += int'(led[k]);
    u = upd[cyc % 64];
    expv = (cyc == last_start + NCH);
    if (cyc >= last_start + NCH + 1 && (u || pend)) begin
      last_start = cyc;
      pend = 0;
      exp_ch = argmax_ch(vis[cyc % 64]);
      exp_lvl = int'(vis[cyc % 64][exp_ch*16 +: 16]);
    end else if (u) pend = 1;
    chk("loudest_valid", loudest_valid, expv);
    if (expv) begin
      exp_pulse_cnt++;
      chk("loudest_ch", loudest_ch, exp_ch);
      chk("loudest_level", loudest_level, exp_lvl);
    end
    if (loudest_valid) begin
      pulse_cnt++;
      if (gap_en && prev_pulse >= 0 && cyc - prev_pulse != NCH + 1) bad_gap++;
      prev_pulse = cyc;
      pulse_cyc = cyc;
      pulse_ch = int'(loudest_ch);
      pulse_lvl = int'(loudest_level);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'($urandom_range(0, 1));
      samples = {$urandom, $urandom, $urandom};
      b_valid = 1'($urandom_range(0, 1));
      b_samples = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      cyc++;
      chk("rst_levels", levels, 0);
      chk("rst_led", led, 0);
      chk("rst_loudest", {loudest_ch, loudest_level}, 0);
      chk("rst_valid", loudest_valid, 0);
      chk("rst_b_levels", b_levels, 0);
      chk("rst_b_misc", {b_led, b_loudest_ch, b_loudest_level, b_loudest_valid}, 0);
    end
    rst_n = 1'b1;
    sample_valid = 1'b0;
    samples = '0;
    b_valid = 1'b0;
    b_samples = '0;
    model_reset();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t_s, p0, n, cur, prev, p_pre, e_pre, fb;
    bit rose;
    logic [15:0] hexp [6];

    tbl[0].s = {24'h0, 24'h7FFF00, 24'h0, 24'h0};
    tbl[0].exp = {16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
    tbl[1].s = '0;
    tbl[1].exp = {16'h0000, 16'h7800, 16'h0000, 16'h0000};
    tbl[2].s = {24'h123456, 24'h000000, 24'hFFFF00, 24'h800000};
    tbl[2].exp = {16'h1234, 16'h7080, 16'h0001, 16'h7FFF};
    tbl[3].s = '0;
    tbl[3].exp = {16'h1111, 16'h6978, 16'h0000, 16'h7800};
    tbl[4].s = {24'h111100, 24'h698000, 24'h000010, 24'h500000};
    tbl[4].exp = {16'h1111, 16'h6980, 16'h0000, 16'h7080};
    hexp[0] = 16'h1000; hexp[1] = 16'h1000; hexp[2] = 16'h1000;
    hexp[3] = 16'h1000; hexp[4] = 16'h0F00; hexp[5] = 16'h0E10;
    for (int k = 0; k < NCH; k++) led_hi[k] = 0;

    do_reset();

    // attack, decay, saturation, ties
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, tbl[i].s);
      tick(1'b0, '0);
      chk($sformatf("table_%0d", i), levels, tbl[i].exp);
    end

    // decay from full scale reaches zero without wrapping
    do_reset();
    tick(1'b1, {24'h0, 24'h7FFF00, 48'h0});
    tick(1'b0, '0);
    prev = int'(levels[47:32]);
    rose = 0;
    n = 0;
    do begin
      tick(1'b1, '0);
      cur = int'(levels[47:32]);
      if (cur > prev) rose = 1;
      prev = cur;
      n++;
    end while (cur != 0 && n < 600);
    chk("decay_reaches_zero", (cur == 0), 1);
    chk("decay_monotonic", rose, 0);
    for (int i = 0; i < 8; i++) tick(1'b0, '0);

    // hold time on the second instance
    do_reset();
    for (int i = 0; i < 6; i++) begin
      b_valid = 1'b1;
      b_samples = (i == 0) ? 96'h100000 : '0;
      tick(1'b0, '0);
      b_valid = 1'b0;
      b_samples = '0;
      tick(1'b0, '0);
      chk($sformatf("hold_%0d", i), b_levels[15:0], hexp[i]);
      tick(1'b0, '0);
    end

    // arg-max with a tie, latency from strobe
    do_reset();
    t_s = cyc;
    p0 = pulse_cnt;
    tick(1'b1, {24'h020000, 24'h050000, 24'h050000, 24'h010000});
    n = 0;
    while (pulse_cnt == p0 && n < 20) begin tick(1'b0, '0); n++; end
    chk("argmax_seen", (pulse_cnt == p0 + 1), 1);
    chk("argmax_latency", pulse_cyc - t_s, 6);
    chk("argmax_ch", pulse_ch, 1);
    chk("argmax_level", pulse_lvl, 16'h0500);

    // strobes every cycle
    do_reset();
    p_pre = pulse_cnt;
    e_pre = exp_pulse_cnt;
    gap_en = 1;
    prev_pulse = -1;
    bad_gap = 0;
    for (int i = 0; i < 60; i++)
      tick(1'b1, {rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample()});
    for (int i = 0; i < 20; i++) tick(1'b0, '0);
    gap_en = 0;
    chk("b2b_pulse_count", pulse_cnt - p_pre, exp_pulse_cnt - e_pre);
    chk("b2b_gap", bad_gap, 0);
    fb = argmax_ch(pack_model());
    chk("b2b_final_ch", pulse_ch, fb);
    chk("b2b_final_level", pulse_lvl, mlev[fb]);

    // reset in the middle of a scan produces no pulse
    tick(1'b1, {rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample()});
    for (int i = 0; i < 3; i++) tick(1'b0, '0);
    do_reset();
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) tick(1'b0, '0);
    chk("midscan_no_pulse", pulse_cnt, p0);

    // random traffic against the model
    for (int i = 0; i < 300; i++)
      tick(($urandom_range(0, 2) == 0),
           {rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample()});
    for (int i = 0; i < 10; i++) tick(1'b0, '0);

    // PWM duty over one full counter period
    do_reset();
    tick(1'b1, {24'h200000, 24'h7FFFFF, 24'h000000, 24'h400000});
    for (int i = 0; i < 4; i++) tick(1'b0, '0);
    for (int k = 0; k < NCH; k++) led_hi[k] = 0;
    for (int i = 0; i < 256; i++) tick(1'b0, '0);
    chk("pwm_ch0_0x4000", led_hi[0], 64);
    chk("pwm_ch1_zero", led_hi[1], 0);
    chk("pwm_ch2_0x7fff", led_hi[2], 127);
    chk("pwm_ch3_0x2000", led_hi[3], 32);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
